// File: rtl/name_entry_pkg.sv
// Shared types, constants and letter-wrap helpers for the name entry controller.
package name_entry_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EDIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0]  POS_CONFIRM = 2'd3;
  localparam int unsigned CHAR_W      = 5;
  localparam int unsigned NAME_LEN    = 3;

  // Next letter, wrapping the last letter back to 'A'.
  function automatic logic [CHAR_W-1:0] char_inc(input logic [CHAR_W-1:0] ch,
                                                  input int unsigned n);
    if (32'(ch) >= n - 1) return '0;
    return ch + CHAR_W'(1);
  endfunction

  // Previous letter, wrapping 'A' to the last letter.
  function automatic logic [CHAR_W-1:0] char_dec(input logic [CHAR_W-1:0] ch,
                                                  input int unsigned n);
    if (ch == '0 || 32'(ch) >= n) return CHAR_W'(n - 1);
    return ch - CHAR_W'(1);
  endfunction

endpackage

// File: rtl/name_entry_ctrl_btn_repeat.sv
// Rising-edge step with hold-to-auto-repeat for one debounced button.
module btn_repeat #(
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  input  logic hold_clr,
  output logic step_c
);

  // The rising edge already steps, so the delay countdown starts one lower.
  localparam int unsigned DELAY_LOAD = (REPEAT_DELAY > 1) ? REPEAT_DELAY - 1 : 1;
  localparam int unsigned RATE_LOAD  = (REPEAT_RATE > 0) ? REPEAT_RATE : 1;
  localparam int unsigned CNT_MAX    = (DELAY_LOAD > RATE_LOAD) ? DELAY_LOAD : RATE_LOAD;
  localparam int unsigned CNT_W      = $clog2(CNT_MAX + 1);

  logic             prev;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  assign rise   = level & ~prev;
  assign step_c = ~hold_clr & (rise | (level & (cnt == CNT_W'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
      cnt  <= '0;
    end else begin
      prev <= level;
      if (hold_clr || !level) cnt <= '0;
      else if (rise)                cnt <= CNT_W'(DELAY_LOAD);
      else if (cnt == CNT_W'(1))    cnt <= CNT_W'(RATE_LOAD);
      else if (cnt != '0)           cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/name_entry_ctrl.sv
// Three-letter player name editor: cursor, letter cycling with auto-repeat, confirm.
module name_entry_ctrl
  import name_entry_pkg::*;
#(
  parameter int unsigned NUM_CHARS    = 26,
  parameter int unsigned REPEAT_DELAY = 12_500_000,
  parameter int unsigned REPEAT_RATE  = 2_500_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_confirm,
  output logic [1:0]  input_pos,
  output logic [14:0] player_name,
  output logic        busy,
  output logic        name_done
);

  state_t            state;
  logic [CHAR_W-1:0] chars [NAME_LEN];
  logic              prev_left, prev_right, prev_confirm;
  logic              left_ev, right_ev, confirm_ev;
  logic              up_step, down_step, hold_clr;

  assign left_ev    = btn_left    & ~prev_left;
  assign right_ev   = btn_right   & ~prev_right;
  assign confirm_ev = btn_confirm & ~prev_confirm;

  // Repeat counters stay idle outside EDIT and on the confirm box.
  assign hold_clr = (state != EDIT) || (input_pos == POS_CONFIRM);

  assign player_name = {chars[0], chars[1], chars[2]};

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_up (
    .clk(clk), .rst_n(rst_n), .level(btn_up), .hold_clr(hold_clr), .step_c(up_step)
  );

  btn_repeat #(.REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE)) u_down (
    .clk(clk), .rst_n(rst_n), .level(btn_down), .hold_clr(hold_clr), .step_c(down_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      input_pos    <= '0;
      chars        <= '{default: '0};
      busy         <= 1'b0;
      name_done    <= 1'b0;
      prev_left    <= 1'b0;
      prev_right   <= 1'b0;
      prev_confirm <= 1'b0;
    end else begin
      prev_left    <= btn_left;
      prev_right   <= btn_right;
      prev_confirm <= btn_confirm;
      name_done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= EDIT;
            input_pos <= '0;
            chars     <= '{default: '0};
            busy      <= 1'b1;
          end
        end
        EDIT: begin
          // One action per cycle: confirm, then cursor, then letter.
          if (confirm_ev) begin
            if (input_pos == POS_CONFIRM) begin
              state     <= DONE;
              busy      <= 1'b0;
              name_done <= 1'b1;
            end else begin
              input_pos <= input_pos + 2'd1;
            end
          end else if (left_ev ^ right_ev) begin
            input_pos <= left_ev ? input_pos - 2'd1 : input_pos + 2'd1;
          end else if ((input_pos != POS_CONFIRM) && (up_step ^ down_step)) begin
            chars[input_pos] <= up_step ? char_inc(chars[input_pos], NUM_CHARS)
                                        : char_dec(chars[input_pos], NUM_CHARS);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_name_entry_ctrl.sv
// Directed table-driven bench for name_entry_ctrl with short repeat timing.
module tb_name_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, btn_left, btn_right, btn_up, btn_down, btn_confirm;
  logic [1:0]  input_pos;
  logic [14:0] player_name;
  logic        busy, name_done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  name_entry_ctrl #(.NUM_CHARS(26), .REPEAT_DELAY(8), .REPEAT_RATE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .btn_left(btn_left), .btn_right(btn_right), .btn_up(btn_up),
    .btn_down(btn_down), .btn_confirm(btn_confirm),
    .input_pos(input_pos), .player_name(player_name),
    .busy(busy), .name_done(name_done)
  );

  typedef struct packed {
    logic        l, r, u, d, c, s;
    logic [1:0]  pos;
    logic [14:0] name;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input logic [1:0] pos,
                       input logic [14:0] name, input logic bsy, input logic dn);
    checks++;
    if (input_pos !== pos || player_name !== name || busy !== bsy || name_done !== dn) begin
      failures++;
      $display("FAIL %s[%0d]: got pos=%0d name=%h busy=%b done=%b, want pos=%0d name=%h busy=%b done=%b",
               nm, idx, input_pos, player_name, busy, name_done, pos, name, bsy, dn);
    end
  endtask

  task automatic add(input logic l, r, u, d, c, s, input logic [1:0] pos,
                     input logic [14:0] name, input logic bsy, input logic dn);
    vec_t v;
    v = '{l:l, r:r, u:u, d:d, c:c, s:s, pos:pos, name:name, busy:bsy, done:dn};
    vecs.push_back(v);
  endtask

  task automatic set_btns(input logic l, r, u, d, c, s);
    btn_left = l; btn_right = r; btn_up = u; btn_down = d; btn_confirm = c; start = s;
  endtask

  // which: 0=left 1=right 2=up 3=down 4=confirm
  task automatic press(input int which);
    set_btns(which == 0, which == 1, which == 2, which == 3, which == 4, 1'b0);
    tick();
    set_btns(0, 0, 0, 0, 0, 0);
    tick();
  endtask

  initial begin
    int exp_ch;
    rst_n = 1'b0;
    set_btns(0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    check("reset", 0, 2'd0, 15'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    check("idle", 0, 2'd0, 15'h0000, 1'b0, 1'b0);

    //   l  r  u  d  c  s   pos   name      busy done
    add(0, 0, 0, 0, 0, 1, 2'd0, 15'h0000, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0000, 1, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 15'h0400, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0400, 1, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 15'h0800, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0800, 1, 0);
    add(0, 0, 1, 0, 0, 0, 2'd0, 15'h0C00, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0C00, 1, 0);
    add(0, 1, 0, 0, 0, 0, 2'd1, 15'h0C00, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 15'h0C00, 1, 0);
    add(0, 0, 0, 1, 0, 0, 2'd1, 15'h0F20, 1, 0); // 'D','Z','A'
    add(0, 0, 0, 0, 0, 0, 2'd1, 15'h0F20, 1, 0);
    add(1, 1, 1, 0, 0, 0, 2'd1, 15'h0C00, 1, 0); // l+r cancel, 'Z'->'A'
    add(0, 0, 0, 0, 0, 1, 2'd1, 15'h0C00, 1, 0); // start ignored in EDIT
    add(0, 0, 1, 0, 1, 0, 2'd2, 15'h0C00, 1, 0); // confirm wins over up
    add(0, 0, 0, 0, 0, 0, 2'd2, 15'h0C00, 1, 0);
    add(0, 0, 1, 0, 0, 0, 2'd2, 15'h0C01, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd2, 15'h0C01, 1, 0);
    add(1, 0, 0, 0, 0, 0, 2'd1, 15'h0C01, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 15'h0C01, 1, 0);
    add(1, 0, 0, 0, 0, 0, 2'd0, 15'h0C01, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0C01, 1, 0);
    add(1, 0, 0, 0, 0, 0, 2'd3, 15'h0C01, 1, 0); // 0 -> 3 wrap
    add(0, 0, 0, 0, 0, 0, 2'd3, 15'h0C01, 1, 0);
    add(0, 0, 1, 0, 0, 0, 2'd3, 15'h0C01, 1, 0); // up on confirm box ignored
    add(0, 0, 0, 0, 0, 0, 2'd3, 15'h0C01, 1, 0);
    add(0, 1, 0, 0, 0, 0, 2'd0, 15'h0C01, 1, 0); // 3 -> 0 wrap
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0C01, 1, 0);
    add(0, 0, 0, 1, 0, 0, 2'd0, 15'h0801, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0801, 1, 0);
    add(0, 1, 0, 0, 0, 0, 2'd1, 15'h0801, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd1, 15'h0801, 1, 0);
    add(0, 0, 0, 1, 0, 0, 2'd1, 15'h0B21, 1, 0); // 'A' -> 'Z'
    add(0, 0, 0, 0, 0, 0, 2'd1, 15'h0B21, 1, 0);
    add(0, 0, 1, 1, 0, 0, 2'd1, 15'h0B21, 1, 0); // up+down cancel
    add(0, 0, 0, 0, 0, 0, 2'd1, 15'h0B21, 1, 0);
    add(1, 0, 0, 0, 0, 0, 2'd0, 15'h0B21, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd0, 15'h0B21, 1, 0);
    add(1, 0, 0, 0, 0, 0, 2'd3, 15'h0B21, 1, 0);
    add(0, 0, 0, 0, 0, 0, 2'd3, 15'h0B21, 1, 0);
    add(0, 0, 0, 0, 1, 0, 2'd3, 15'h0B21, 0, 1); // DONE
    add(0, 0, 0, 0, 0, 0, 2'd3, 15'h0B21, 0, 0); // back to IDLE
    add(1, 0, 1, 0, 0, 0, 2'd3, 15'h0B21, 0, 0);
    add(0, 1, 0, 1, 1, 0, 2'd3, 15'h0B21, 0, 0);
    add(0, 0, 0, 0, 0, 0, 2'd3, 15'h0B21, 0, 0);

    foreach (vecs[i]) begin
      set_btns(vecs[i].l, vecs[i].r, vecs[i].u, vecs[i].d, vecs[i].c, vecs[i].s);
      tick();
      check("vec", i, vecs[i].pos, vecs[i].name, vecs[i].busy, vecs[i].done);
    end
    set_btns(0, 0, 0, 0, 0, 0);

    // Auto-repeat: steps visible after edges 1, 8, 12, 16, 20 of a 20-cycle hold.
    set_btns(0, 0, 0, 0, 0, 1);
    tick();
    set_btns(0, 0, 0, 0, 0, 0);
    check("restart", 0, 2'd0, 15'h0000, 1'b1, 1'b0);
    btn_up = 1'b1;
    exp_ch = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1 || k == 8 || k == 12 || k == 16 || k == 20) exp_ch++;
      check("repeat", k, 2'd0, 15'(exp_ch << 10), 1'b1, 1'b0);
    end
    btn_up = 1'b0;
    repeat (5) tick();
    check("repeat_release", 0, 2'd0, 15'h1400, 1'b1, 1'b0);

    // Confirm through all slots to finish.
    for (int k = 0; k < 4; k++) press(4);
    check("done_idle", 0, 2'd3, 15'h1400, 1'b0, 1'b0);

    // Button held across start must not step.
    btn_up = 1'b1;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (12) tick();
    check("held_across_start", 0, 2'd0, 15'h0000, 1'b1, 1'b0);
    btn_up = 1'b0;
    tick();

    // Build "CAB" then reset mid-cycle.
    press(2); press(2); press(1); press(1); press(2);
    check("cab", 0, 2'd2, 15'h0801, 1'b1, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset", 0, 2'd0, 15'h0000, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("in_reset", k, 2'd0, 15'h0000, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("post_reset", k, 2'd0, 15'h0000, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
